// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown timer:
//   - state_e      : controller state encoding
//   - DIGIT_W      : width of one BCD digit
//   - MMSS_W       : width of a packed MM:SS BCD word
//   - secs_to_mmss : constant function converting seconds to packed MM:SS BCD
// -----------------------------------------------------------------------------
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_e;

   localparam int DIGIT_W = 4;
   localparam int MMSS_W  = 4 * DIGIT_W;

   // Seconds (0..5999) to {min tens, min units, sec tens, sec units}.
   function automatic logic [MMSS_W-1:0] secs_to_mmss(input int unsigned secs);
      int unsigned mins;
      int unsigned rem;
      mins = secs / 60;
      rem  = secs % 60;
      return {DIGIT_W'(mins / 10), DIGIT_W'(mins % 10),
              DIGIT_W'(rem / 10),  DIGIT_W'(rem % 10)};
   endfunction

endpackage : timer_pkg

// File: rtl/mmss_step.sv
// -----------------------------------------------------------------------------
// mmss_step
// Combinational +/-1 second on a packed MM:SS BCD word with wrap-around
// (99:59 + 1 -> 00:00, 00:00 - 1 -> 99:59). inc_i and dec_i together, or
// neither, pass the word through unchanged.
//   mmss_i : current MM:SS word
//   inc_i  : add one second
//   dec_i  : subtract one second
//   mmss_o : stepped MM:SS word
// -----------------------------------------------------------------------------
module mmss_step
   import timer_pkg::*;
(
   input  logic [MMSS_W-1:0] mmss_i,
   input  logic              inc_i,
   input  logic              dec_i,
   output logic [MMSS_W-1:0] mmss_o
);

   logic               up;
   logic               carry;
   logic [DIGIT_W-1:0] dig;
   logic [DIGIT_W-1:0] lim;

   // Ripple the carry/borrow from sec units upwards; sec tens tops out at 5,
   // every other digit at 9.
   // NOTE: every variable in a combinational block gets a value before any
   // branch, otherwise synthesis infers a latch to hold the old value.
   always_comb begin
      mmss_o = mmss_i;
      up     = inc_i;
      carry  = inc_i ^ dec_i;
      dig    = '0;
      lim    = '0;
      for (int i = 0; i < 4; i++) begin
         dig = mmss_i[i*DIGIT_W +: DIGIT_W];
         lim = (i == 1) ? DIGIT_W'(5) : DIGIT_W'(9);
         if (carry) begin
            if (up) begin
               if (dig == lim) begin
                  mmss_o[i*DIGIT_W +: DIGIT_W] = '0;
               end else begin
                  mmss_o[i*DIGIT_W +: DIGIT_W] = dig + DIGIT_W'(1);
                  carry = 1'b0;
               end
            end else begin
               if (dig == '0) begin
                  mmss_o[i*DIGIT_W +: DIGIT_W] = lim;
               end else begin
                  mmss_o[i*DIGIT_W +: DIGIT_W] = dig - DIGIT_W'(1);
                  carry = 1'b0;
               end
            end
         end
      end
   end

endmodule : mmss_step

// File: rtl/countdown_ctrl.sv
// -----------------------------------------------------------------------------
// countdown_ctrl
// Countdown timer control core. Holds MM:SS in packed BCD and sequences
// set (IDLE), run (RUN), pause (PAUSE) and alarm (ALARM).
//   CLK       : system clock
//   CLR       : asynchronous active-low reset
//   CE        : global clock enable, qualifies every input pulse
//   TICK      : 1 Hz one-cycle pulse
//   BLINK_CE  : 1 ms one-cycle pulse for the blink timebase
//   KEY_START : start/pause key pulse
//   KEY_INC   : increment key pulse
//   KEY_DEC   : decrement key pulse
//   Q         : {min tens, min units, sec tens, sec units} BCD
//   E         : digit enable mask, bit 3 = min tens
//   RUNNING   : high in RUN
//   ALARM     : high in ALARM
// -----------------------------------------------------------------------------
module countdown_ctrl
   import timer_pkg::*;
#(
   parameter int DEFAULT_SECS = 60,
   parameter int BLINK_DIV    = 500,
   parameter int ALARM_SECS   = 10
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              CE,
   input  logic              TICK,
   input  logic              BLINK_CE,
   input  logic              KEY_START,
   input  logic              KEY_INC,
   input  logic              KEY_DEC,
   output logic [MMSS_W-1:0] Q,
   output logic [3:0]        E,
   output logic              RUNNING,
   output logic              ALARM
);

   if (DEFAULT_SECS < 0 || DEFAULT_SECS > 5999) begin : g_bad_default
      $error("countdown_ctrl: DEFAULT_SECS must be in 0..5999");
   end
   if (BLINK_DIV < 1) begin : g_bad_blink
      $error("countdown_ctrl: BLINK_DIV must be at least 1");
   end
   if (ALARM_SECS < 1) begin : g_bad_alarm
      $error("countdown_ctrl: ALARM_SECS must be at least 1");
   end

   localparam logic [MMSS_W-1:0] DEFAULT_MMSS = secs_to_mmss(DEFAULT_SECS);
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int ALARM_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
   localparam logic [ALARM_W-1:0] ALARM_LAST = ALARM_W'(ALARM_SECS - 1);

   state_e              state_q,     state_d;
   logic [MMSS_W-1:0]   q_q,         q_d;
   logic [MMSS_W-1:0]   preset_q,    preset_d;
   logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
   logic                blink_on_q,  blink_on_d;
   logic [ALARM_W-1:0]  alarm_cnt_q, alarm_cnt_d;
   logic [3:0]          e_q,         e_d;
   logic                running_q,   running_d;
   logic                alarm_q,     alarm_d;

   logic                step_inc;
   logic                step_dec;
   logic [MMSS_W-1:0]   step_word;
   logic                any_key;

   assign any_key = KEY_START | KEY_INC | KEY_DEC;

   // One shared stepper: keys step in IDLE/PAUSE, TICK steps in RUN, and the
   // two paths never apply in the same cycle. START outranks INC/DEC.
   always_comb begin
      step_inc = 1'b0;
      step_dec = 1'b0;
      if (CE) begin
         unique case (state_q)
            ST_IDLE, ST_PAUSE: begin
               if (!KEY_START) begin
                  step_inc = KEY_INC & ~KEY_DEC;
                  step_dec = KEY_DEC & ~KEY_INC;
               end
            end
            ST_RUN:   step_dec = TICK;
            default:  ;
         endcase
      end
   end

   mmss_step u_step (
      .mmss_i (q_q),
      .inc_i  (step_inc),
      .dec_i  (step_dec),
      .mmss_o (step_word)
   );

   always_comb begin
      state_d     = state_q;
      q_d         = q_q;
      preset_d    = preset_q;
      alarm_cnt_d = alarm_cnt_q;
      blink_cnt_d = blink_cnt_q;
      blink_on_d  = blink_on_q;

      if (CE) begin
         unique case (state_q)
            ST_IDLE: begin
               if (KEY_START) begin
                  if (q_q != '0) begin
                     state_d  = ST_RUN;
                     preset_d = q_q;
                  end
               end else begin
                  q_d = step_word;
               end
            end
            ST_RUN: begin
               // Reaching 00:00 wins over a simultaneous pause request.
               if (TICK) begin
                  q_d = step_word;
                  if (step_word == '0)  state_d = ST_ALARM;
                  else if (KEY_START)   state_d = ST_PAUSE;
               end else if (KEY_START) begin
                  state_d = ST_PAUSE;
               end
            end
            ST_PAUSE: begin
               if (KEY_START) begin
                  state_d = (q_q != '0) ? ST_RUN : ST_IDLE;
               end else begin
                  q_d = step_word;
               end
            end
            ST_ALARM: begin
               // The key that ends the alarm is consumed here and does nothing else.
               if (any_key || (TICK && alarm_cnt_q == ALARM_LAST)) begin
                  state_d = ST_IDLE;
                  q_d     = preset_q;
               end else if (TICK) begin
                  alarm_cnt_d = alarm_cnt_q + ALARM_W'(1);
               end
            end
            default: state_d = ST_IDLE;
         endcase

         // Counters restart and blink phase returns to "on" at every state entry.
         if (state_d != state_q) begin
            alarm_cnt_d = '0;
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
         end else if (BLINK_CE) begin
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_d = '0;
               blink_on_d  = ~blink_on_q;
            end else begin
               blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
         end
      end

      e_d       = (state_d == ST_IDLE || state_d == ST_RUN || blink_on_d) ? 4'hF : 4'h0;
      running_d = (state_d == ST_RUN);
      alarm_d   = (state_d == ST_ALARM);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q     <= ST_IDLE;
         q_q         <= DEFAULT_MMSS;
         preset_q    <= DEFAULT_MMSS;
         blink_cnt_q <= '0;
         blink_on_q  <= 1'b1;
         alarm_cnt_q <= '0;
         e_q         <= 4'hF;
         running_q   <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         q_q         <= q_d;
         preset_q    <= preset_d;
         blink_cnt_q <= blink_cnt_d;
         blink_on_q  <= blink_on_d;
         alarm_cnt_q <= alarm_cnt_d;
         e_q         <= e_d;
         running_q   <= running_d;
         alarm_q     <= alarm_d;
      end
   end

   assign Q       = q_q;
   assign E       = e_q;
   assign RUNNING = running_q;
   assign ALARM   = alarm_q;

endmodule : countdown_ctrl

// File: tb/tb_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_countdown_ctrl
// Directed self-checking bench for countdown_ctrl with DEFAULT_SECS=60,
// BLINK_DIV=500, ALARM_SECS=10. Inputs change on the falling edge and
// outputs are sampled on the following falling edge.
// -----------------------------------------------------------------------------
module tb_countdown_ctrl;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        CE;
   logic        TICK;
   logic        BLINK_CE;
   logic        KEY_START;
   logic        KEY_INC;
   logic        KEY_DEC;
   logic [15:0] Q;
   logic [3:0]  E;
   logic        RUNNING;
   logic        ALARM;

   int n_checks = 0;
   int n_errors = 0;

   countdown_ctrl #(
      .DEFAULT_SECS (60),
      .BLINK_DIV    (500),
      .ALARM_SECS   (10)
   ) dut (
      .CLK       (CLK),
      .CLR       (CLR),
      .CE        (CE),
      .TICK      (TICK),
      .BLINK_CE  (BLINK_CE),
      .KEY_START (KEY_START),
      .KEY_INC   (KEY_INC),
      .KEY_DEC   (KEY_DEC),
      .Q         (Q),
      .E         (E),
      .RUNNING   (RUNNING),
      .ALARM     (ALARM)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   // Apply one cycle of input pulses starting at a falling edge; return at
   // the next falling edge with all pulses cleared.
   task automatic cyc(input logic st, input logic inc, input logic dec,
                      input logic tk, input logic bl);
      KEY_START = st;
      KEY_INC   = inc;
      KEY_DEC   = dec;
      TICK      = tk;
      BLINK_CE  = bl;
      @(negedge CLK);
      KEY_START = 1'b0;
      KEY_INC   = 1'b0;
      KEY_DEC   = 1'b0;
      TICK      = 1'b0;
      BLINK_CE  = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      CLR = 1'b0; CE = 1'b1;
      TICK = 1'b0; BLINK_CE = 1'b0;
      KEY_START = 1'b0; KEY_INC = 1'b0; KEY_DEC = 1'b0;
      repeat (3) @(negedge CLK);
      CLR = 1'b1;

      // Reset state
      check("reset_q",       Q,       32'h0100);
      check("reset_e",       E,       32'hF);
      check("reset_running", RUNNING, 32'd0);
      check("reset_alarm",   ALARM,   32'd0);

      // IDLE decrement with BCD borrow
      repeat (3) cyc(0, 0, 1, 0, 0);
      check("dec3_q", Q, 32'h0057);
      repeat (57) cyc(0, 0, 1, 0, 0);
      check("dec_to_zero_q", Q, 32'h0000);

      // Wrap at 00:00 both ways, START ignored at 00:00
      cyc(0, 0, 1, 0, 0);
      check("dec_wrap_q", Q, 32'h9959);
      cyc(0, 1, 0, 0, 0);
      check("inc_wrap_q", Q, 32'h0000);
      cyc(0, 1, 1, 0, 0);
      check("inc_dec_together_q", Q, 32'h0000);
      cyc(1, 0, 0, 0, 0);
      check("start_zero_running", RUNNING, 32'd0);
      check("start_zero_q",       Q,       32'h0000);

      // Run from 00:03 into ALARM, then alarm timeout reloads PRESET
      repeat (3) cyc(0, 1, 0, 0, 0);
      check("inc3_q", Q, 32'h0003);
      cyc(1, 0, 0, 0, 0);
      check("start_running", RUNNING, 32'd1);
      cyc(0, 1, 0, 0, 0);
      check("run_inc_ignored_q", Q, 32'h0003);
      cyc(0, 0, 0, 1, 0);
      check("tick1_q", Q, 32'h0002);
      cyc(0, 0, 0, 1, 0);
      check("tick2_q", Q, 32'h0001);
      check("tick2_alarm", ALARM, 32'd0);
      cyc(0, 0, 0, 1, 0);
      check("tick3_q",       Q,       32'h0000);
      check("tick3_alarm",   ALARM,   32'd1);
      check("tick3_running", RUNNING, 32'd0);
      repeat (9) cyc(0, 0, 0, 1, 0);
      check("alarm_9ticks_alarm", ALARM, 32'd1);
      check("alarm_9ticks_q",     Q,     32'h0000);
      cyc(0, 0, 0, 1, 0);
      check("alarm_timeout_alarm", ALARM, 32'd0);
      check("alarm_timeout_q",     Q,     32'h0003);
      check("alarm_timeout_e",     E,     32'hF);

      // RUN at 01:00, TICK+START together -> 00:59 in PAUSE, then blink
      repeat (57) cyc(0, 1, 0, 0, 0);
      check("inc_to_0100_q", Q, 32'h0100);
      cyc(1, 0, 0, 0, 0);
      check("start2_running", RUNNING, 32'd1);
      cyc(1, 0, 0, 1, 0);
      check("tick_start_q",       Q,       32'h0059);
      check("tick_start_running", RUNNING, 32'd0);
      check("tick_start_alarm",   ALARM,   32'd0);
      check("pause_entry_e",      E,       32'hF);
      repeat (499) cyc(0, 0, 0, 0, 1);
      check("blink_499_e", E, 32'hF);
      cyc(0, 0, 0, 0, 1);
      check("blink_500_e", E, 32'h0);
      repeat (500) cyc(0, 0, 0, 0, 1);
      check("blink_1000_e", E, 32'hF);
      repeat (500) cyc(0, 0, 0, 0, 1);
      check("blink_1500_e", E, 32'h0);
      cyc(0, 1, 0, 0, 0);
      check("pause_inc_q", Q, 32'h0100);
      cyc(1, 0, 0, 0, 0);
      check("resume_running", RUNNING, 32'd1);
      check("resume_e",       E,       32'hF);

      // RUN at 00:01, TICK+START together -> ALARM; INC ends it with no step
      repeat (59) cyc(0, 0, 0, 1, 0);
      check("run_to_0001_q", Q, 32'h0001);
      cyc(1, 0, 0, 1, 0);
      check("last_tick_start_alarm",   ALARM,   32'd1);
      check("last_tick_start_running", RUNNING, 32'd0);
      check("last_tick_start_q",       Q,       32'h0000);
      cyc(0, 1, 0, 0, 0);
      check("alarm_key_alarm", ALARM, 32'd0);
      check("alarm_key_q",     Q,     32'h0100);
      check("alarm_key_e",     E,     32'hF);

      // CE low drops pulses
      CE = 1'b0;
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0);
      check("ce_low_idle_q",       Q,       32'h0100);
      check("ce_low_idle_running", RUNNING, 32'd0);
      CE = 1'b1;
      cyc(1, 0, 0, 0, 0);
      check("ce_start_running", RUNNING, 32'd1);
      repeat (3) cyc(0, 0, 0, 1, 0);
      check("ce_run_q", Q, 32'h0057);
      CE = 1'b0;
      cyc(0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0);
      check("ce_low_run_q",       Q,       32'h0057);
      check("ce_low_run_running", RUNNING, 32'd1);

      // Asynchronous reset mid-run while CE toggles
      CE = 1'b1;
      #2 CE = 1'b0;
      #1 CLR = 1'b0;
      #1;
      check("async_reset_q",       Q,       32'h0100);
      check("async_reset_running", RUNNING, 32'd0);
      check("async_reset_alarm",   ALARM,   32'd0);
      check("async_reset_e",       E,       32'hF);
      CE = 1'b1;
      @(negedge CLK);
      CLR = 1'b1;
      cyc(0, 0, 0, 1, 0);
      check("post_reset_tick_q",       Q,       32'h0100);
      check("post_reset_tick_running", RUNNING, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_countdown_ctrl

// File: doc/countdown_ctrl.md
# countdown_ctrl

Countdown control core for the countdown timer: holds the MM:SS value in packed BCD and sequences set, run, pause and alarm. Inputs are one-cycle key pulses from the switch debouncers and a 1 Hz tick from the timer prescaler. It drives the 4-digit BCD word and per-digit enable mask consumed directly by the 7-segment display driver, replacing the binary-counter plus BCD-conversion path.

## Interface
- DEFAULT_SECS, 60: preset after reset, in seconds; legal range 0..5999; elaboration error outside it.
- BLINK_DIV, 500: BLINK_CE pulses per blink half-period (500 ms at 1 ms refresh).
- ALARM_SECS, 10: alarm duration in TICK pulses.

- CLK  input  1  system clock.
- CLR  input  1  reset, asynchronous, active-low.
- CE  input  1  global clock enable; no state changes while low.
- TICK  input  1  1 Hz one-cycle pulse (prescaler CEO).
- BLINK_CE  input  1  1 ms one-cycle pulse (refresh CEO).
- KEY_START  input  1  debounced start/pause pulse.
- KEY_INC  input  1  debounced increment pulse (auto-repeat allowed).
- KEY_DEC  input  1  debounced decrement pulse (auto-repeat allowed).
- Q  output  16  BCD {min tens, min units, sec tens, sec units}.
- E  output  4  digit enable mask, bit 3 = min tens.
- RUNNING  output  1  high in RUN.
- ALARM  output  1  high in ALARM.

## Operation
- All inputs are qualified by CE; an event counts only when both the pulse and CE are high.
- Key priority within one cycle: KEY_START > KEY_INC/KEY_DEC. KEY_INC and KEY_DEC together: no change.
- Step arithmetic: ±1 s with BCD carry/borrow. Sec units 0-9, sec tens 0-5, minutes 00-99. INC wraps 99:59 -> 00:00. DEC wraps 00:00 -> 99:59.
- PRESET register: holds DEFAULT_SECS as MM:SS after reset; captured from Q on every IDLE->RUN transition.
- IDLE (reset state):
  - INC/DEC step Q.
  - START with Q != 00:00 -> RUN, capturing PRESET.
  - START with Q == 00:00 is ignored.
- RUN:
  - TICK decrements Q.
  - A decrement reaching 00:00 -> ALARM.
  - START -> PAUSE.
  - INC/DEC are ignored.
  - TICK and START in the same cycle: the decrement applies, then PAUSE. Reaching 00:00 overrides the pause and the block enters ALARM.
- PAUSE:
  - INC/DEC step Q.
  - START -> RUN if Q != 00:00, else -> IDLE.
  - All digits blink.
- ALARM:
  - Q holds 00:00, all digits blink, ALARM=1.
  - Alarm counter counts TICK pulses. On reaching ALARM_SECS, or on any key, the block goes to IDLE and reloads Q <= PRESET.
  - The key that ends ALARM has no further effect.
- Blink: a counter counts BLINK_CE; phase toggles every BLINK_DIV pulses. Counter and phase reset to "on" at every state entry. E = 4'b1111 when the phase is on or in IDLE/RUN, else 4'b0000.
- Leading-zero blanking is not performed here.

## Timing
- Reset values:
  - state = IDLE.
  - Q = DEFAULT_SECS as MM:SS (60 -> 16'h0100).
  - PRESET = same value as Q.
  - E = 4'b1111.
  - RUNNING = 0, ALARM = 0.
  - Blink and alarm counters = 0.
- All outputs are registered. Q, RUNNING and ALARM change on the clock edge following the qualifying input cycle, a latency of 1 cycle.
- E toggles 1 cycle after the BLINK_CE pulse that completes a half-period.
- Reset asserted mid-run returns all state to reset values immediately. No event is lost or replayed after deassertion.
- CE low for any number of cycles freezes state, counters and outputs. Pulses during that time are dropped, not queued.

## Structure
- Shared package (timer_pkg) holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, ALARM=2'd3);
  - BCD digit width and MM:SS width constants;
  - constant function secs_to_mmss(seconds) used for the DEFAULT_SECS conversion.
- Sub-module mmss_step: combinational ±1 s on a 16-bit MM:SS word with wrap. Inputs: the MM:SS word, INC, DEC. Output: the next MM:SS word. Instantiated once and shared by tick and key paths, since at most one applies per cycle.
- Blink and alarm counters stay inline in countdown_ctrl.

## Test plan
- Reset with DEFAULT_SECS=60 -> Q=16'h0100, E=4'hF, RUNNING=0, ALARM=0. Three KEY_DEC -> Q=16'h0057.
- Q=00:00 in IDLE, KEY_DEC -> 16'h9959; KEY_INC -> 16'h0000; KEY_START -> state stays IDLE.
- Q=00:03, START, 3 TICKs -> Q goes 0002, 0001, 0000. ALARM=1 on the edge after the third tick. 10 further TICKs -> IDLE with Q=16'h0003.
- RUN at 01:00, TICK and KEY_START in the same cycle -> Q=16'h0059 and state PAUSE. E then toggles every 500 BLINK_CE pulses. KEY_START -> RUN with E=4'hF.
- RUN at 00:01, TICK and KEY_START in the same cycle -> ALARM, not PAUSE. KEY_INC during ALARM -> IDLE with Q=PRESET and no increment.
- RUN, CLR pulled low mid-count with CE toggling -> immediate reset values. Pulses while CE=0 leave Q unchanged.
